// File: rtl/rhs_pkg.sv
// Shared constants and command layout for the RHS SPI emulator.
package rhs_pkg;

   localparam int unsigned FRAME_BITS = 32;
   localparam int unsigned BIT_CNT_W  = 6;
   localparam int unsigned REG_W      = 16;
   localparam int unsigned NUM_REGS   = 16;
   localparam int unsigned REG_AW     = 4;
   localparam int unsigned CNT_W      = 12;

   localparam logic [FRAME_BITS-1:0] CLEAR_PATTERN = 32'h6A00_0000;
   localparam logic [REG_W-1:0]      CHIP_ID       = 16'h0020;
   localparam logic [7:0]            CHIP_ID_ADDR  = 8'hFF;

   typedef enum logic [1:0] {
      OP_CONVERT = 2'b00,
      OP_MISC    = 2'b01,
      OP_WRITE   = 2'b10,
      OP_READ    = 2'b11
   } rhs_op_e;

   // Command word as shifted in on MOSI, MSB first.
   typedef struct packed {
      rhs_op_e    op;
      logic [5:0] rsvd;
      logic [7:0] addr;
      logic [15:0] data;
   } rhs_cmd_t;

endpackage

// File: rtl/rhs_sync_edge.sv
// Two-flop synchronizer with single-cycle rise/fall pulses in the clk domain.
module rhs_sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rstn,
   input  logic d_in,
   output logic rise_c,
   output logic fall_c
);

   // [0] metastability stage, [1] synchronized level, [2] previous level
   logic [2:0] sync_q;
   logic [2:0] sync_d;

   // Shift the asynchronous input through the chain.
   always_comb begin
      sync_d = {sync_q[1:0], d_in};
   end

   // Synchronizer flops.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q <= {3{RST_VAL}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign rise_c = sync_q[1] & ~sync_q[2];
   assign fall_c = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/rhs_spi_emulator.sv
// SPI slave emulating the RHS command protocol: 32-bit frames, two-deep response pipeline.
module rhs_spi_emulator
   import rhs_pkg::*;
(
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  SCLK,
   input  logic                  MOSI,
   input  logic                  CS,
   output logic                  MISO,
   output logic                  frame_done,
   output logic                  frame_err,
   output logic [FRAME_BITS-1:0] last_cmd
);

   logic sclk_rise_c;
   logic sclk_fall_c;
   logic cs_rise_c;
   logic cs_fall_c;

   // SCLK idles low between frames.
   rhs_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
      .clk    (clk),
      .rstn   (rstn),
      .d_in   (SCLK),
      .rise_c (sclk_rise_c),
      .fall_c (sclk_fall_c)
   );

   // CS synchronizer resets low so a CS held low across reset yields no falling
   // edge; a frame can only start after CS has been observed high.
   rhs_sync_edge #(.RST_VAL(1'b0)) u_cs_sync (
      .clk    (clk),
      .rstn   (rstn),
      .d_in   (CS),
      .rise_c (cs_rise_c),
      .fall_c (cs_fall_c)
   );

   logic [1:0]            mosi_sync_q, mosi_sync_d;
   logic                  in_frame_q, in_frame_d;
   logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [FRAME_BITS-1:0] rx_q, rx_d;
   logic [FRAME_BITS-2:0] tx_q, tx_d;
   logic                  miso_q, miso_d;
   logic                  frame_done_q, frame_done_d;
   logic                  frame_err_q, frame_err_d;
   logic [FRAME_BITS-1:0] last_cmd_q, last_cmd_d;
   logic [FRAME_BITS-1:0] pipe1_q, pipe1_d;
   logic [FRAME_BITS-1:0] pipe2_q, pipe2_d;
   logic [CNT_W-1:0]      conv_cnt_q, conv_cnt_d;
   logic [REG_W-1:0]      regs_q [NUM_REGS];
   logic [REG_W-1:0]      regs_d [NUM_REGS];

   rhs_cmd_t              cmd_c;
   logic [FRAME_BITS-1:0] resp_c;
   logic                  reg_wr_c;
   logic                  cnt_inc_c;
   logic                  cnt_clr_c;

   assign cmd_c = rhs_cmd_t'(rx_q);

   // Decode the received word into its response and side effects.
   always_comb begin
      resp_c    = '0;
      reg_wr_c  = 1'b0;
      cnt_inc_c = 1'b0;
      cnt_clr_c = 1'b0;
      if (cmd_c == rhs_cmd_t'(CLEAR_PATTERN)) begin
         cnt_clr_c = 1'b1;
      end else begin
         case (cmd_c.op)
            OP_CONVERT: begin
               if (cmd_c.addr[5:0] < 6'(NUM_REGS)) begin
                  resp_c    = {16'h0000, cmd_c.addr[3:0], conv_cnt_q};
                  cnt_inc_c = 1'b1;
               end
            end
            OP_WRITE: begin
               resp_c   = {16'hFFFF, cmd_c.data};
               reg_wr_c = (cmd_c.addr < 8'(NUM_REGS));
            end
            OP_READ: begin
               if (cmd_c.addr < 8'(NUM_REGS)) begin
                  resp_c = {16'h0000, regs_q[cmd_c.addr[REG_AW-1:0]]};
               end else if (cmd_c.addr == CHIP_ID_ADDR) begin
                  resp_c = {16'h0000, CHIP_ID};
               end
            end
            OP_MISC: begin
               resp_c = '0;
            end
         endcase
      end
   end

   // Frame tracking, shifting and frame-end commit.
   always_comb begin
      mosi_sync_d  = {mosi_sync_q[0], MOSI};
      in_frame_d   = in_frame_q;
      bit_cnt_d    = bit_cnt_q;
      rx_d         = rx_q;
      tx_d         = tx_q;
      miso_d       = in_frame_q ? miso_q : 1'b0;
      frame_done_d = 1'b0;
      frame_err_d  = 1'b0;
      last_cmd_d   = last_cmd_q;
      pipe1_d      = pipe1_q;
      pipe2_d      = pipe2_q;
      conv_cnt_d   = conv_cnt_q;
      regs_d       = regs_q;

      if (cs_fall_c) begin
         // Present the oldest pipeline word immediately at frame start.
         in_frame_d = 1'b1;
         bit_cnt_d  = '0;
         tx_d       = pipe2_q[FRAME_BITS-2:0];
         miso_d     = pipe2_q[FRAME_BITS-1];
      end else if (in_frame_q) begin
         if (cs_rise_c) begin
            in_frame_d = 1'b0;
            miso_d     = 1'b0;
            if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS)) begin
               frame_done_d = 1'b1;
               last_cmd_d   = rx_q;
               pipe2_d      = pipe1_q;
               pipe1_d      = resp_c;
               if (reg_wr_c) begin
                  regs_d[cmd_c.addr[REG_AW-1:0]] = cmd_c.data;
               end
               if (cnt_clr_c) begin
                  conv_cnt_d = '0;
               end else if (cnt_inc_c) begin
                  conv_cnt_d = conv_cnt_q + CNT_W'(1);
               end
            end else begin
               frame_err_d = 1'b1;
            end
         end else begin
            if (sclk_rise_c) begin
               rx_d = {rx_q[FRAME_BITS-2:0], mosi_sync_q[1]};
               // Saturate so very long frames can never alias back to 32.
               if (bit_cnt_q != '1) begin
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               end
            end
            if (sclk_fall_c) begin
               miso_d = tx_q[FRAME_BITS-2];
               tx_d   = {tx_q[FRAME_BITS-3:0], 1'b0};
            end
         end
      end
   end

   // State registers; reset discards any frame in progress.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mosi_sync_q  <= '0;
         in_frame_q   <= 1'b0;
         bit_cnt_q    <= '0;
         rx_q         <= '0;
         tx_q         <= '0;
         miso_q       <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
         last_cmd_q   <= '0;
         pipe1_q      <= '0;
         pipe2_q      <= '0;
         conv_cnt_q   <= '0;
         regs_q       <= '{default: '0};
      end else begin
         mosi_sync_q  <= mosi_sync_d;
         in_frame_q   <= in_frame_d;
         bit_cnt_q    <= bit_cnt_d;
         rx_q         <= rx_d;
         tx_q         <= tx_d;
         miso_q       <= miso_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
         last_cmd_q   <= last_cmd_d;
         pipe1_q      <= pipe1_d;
         pipe2_q      <= pipe2_d;
         conv_cnt_q   <= conv_cnt_d;
         regs_q       <= regs_d;
      end
   end

   assign MISO       = miso_q;
   assign frame_done = frame_done_q;
   assign frame_err  = frame_err_q;
   assign last_cmd   = last_cmd_q;

endmodule

// File: tb/tb_rhs_spi_emulator.sv
// Bench for rhs_spi_emulator: directed protocol scenarios plus random frames vs a reference model.
module tb_rhs_spi_emulator;

   localparam int PH   = 5;
   localparam int IDLE = 8;

   logic        clk = 1'b0;
   logic        rstn;
   logic        SCLK;
   logic        MOSI;
   logic        CS;
   logic        MISO;
   logic        frame_done;
   logic        frame_err;
   logic [31:0] last_cmd;

   always #5 clk = ~clk;

   rhs_spi_emulator dut (
      .clk        (clk),
      .rstn       (rstn),
      .SCLK       (SCLK),
      .MOSI       (MOSI),
      .CS         (CS),
      .MISO       (MISO),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .last_cmd   (last_cmd)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   int done_seen = 0;
   int err_seen  = 0;
   logic [31:0] last_miso;

   // Pulse counters sampled away from the active edge.
   always @(negedge clk) begin
      if (frame_done) done_seen++;
      if (frame_err)  err_seen++;
   end

   // ---------------- reference model ----------------
   logic [15:0] m_regs [16];
   int unsigned m_cnt;
   logic [31:0] m_pipe [$];
   logic [31:0] m_last;

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
      m_cnt = 0;
      m_pipe.delete();
      m_pipe.push_back(32'h0);
      m_pipe.push_back(32'h0);
      m_last = 32'h0;
   endtask

   task automatic model_accept(input logic [31:0] w, output logic [31:0] exp_miso);
      logic [31:0] resp;
      int unsigned ch, addr;
      resp = 32'h0;
      ch   = 32'(w[21:16]);
      addr = 32'(w[23:16]);
      if (w == 32'h6A00_0000) begin
         m_cnt = 0;
      end else begin
         case (w[31:30])
            2'b00: if (ch < 16) begin
               resp  = {16'h0000, w[19:16], 12'(m_cnt)};
               m_cnt = (m_cnt + 1) % 4096;
            end
            2'b10: begin
               if (addr < 16) m_regs[addr] = w[15:0];
               resp = {16'hFFFF, w[15:0]};
            end
            2'b11: begin
               if (addr < 16) resp = {16'h0000, m_regs[addr]};
               else if (addr == 255) resp = 32'h0000_0020;
            end
            default: resp = 32'h0;
         endcase
      end
      exp_miso = m_pipe.pop_front();
      m_pipe.push_back(resp);
      m_last = w;
   endtask

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cs_assert();
      @(negedge clk);
      CS = 1'b0;
      repeat (PH) @(negedge clk);
   endtask

   task automatic cs_release();
      repeat (PH) @(negedge clk);
      CS = 1'b1;
      repeat (IDLE) @(negedge clk);
   endtask

   task automatic shift_bits(input logic [31:0] w, input int first, input int n, inout logic [31:0] acc);
      for (int i = first; i < first + n; i++) begin
         MOSI = (i < 32) ? w[5'(31 - i)] : 1'b0;
         repeat (PH) @(negedge clk);
         SCLK = 1'b1;
         acc  = {acc[30:0], MISO};
         repeat (PH) @(negedge clk);
         SCLK = 1'b0;
      end
   endtask

   task automatic do_frame(input string tag, input logic [31:0] w, input int nbits);
      logic [31:0] acc, exp_miso, prev_last;
      int d0, e0;
      acc       = 32'h0;
      d0        = done_seen;
      e0        = err_seen;
      prev_last = m_last;
      cs_assert();
      shift_bits(w, 0, nbits, acc);
      cs_release();
      if (nbits == 32) begin
         model_accept(w, exp_miso);
         check({tag, ":miso"}, acc, exp_miso);
         check({tag, ":done"}, 32'(done_seen - d0), 32'd1);
         check({tag, ":err"},  32'(err_seen - e0),  32'd0);
         check({tag, ":last"}, last_cmd, w);
      end else begin
         check({tag, ":done"}, 32'(done_seen - d0), 32'd0);
         check({tag, ":err"},  32'(err_seen - e0),  32'd1);
         check({tag, ":last"}, last_cmd, prev_last);
      end
      check({tag, ":idle"}, 32'(MISO), 32'd0);
      last_miso = acc;
   endtask

   task automatic apply_reset();
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      model_reset();
      repeat (4) @(negedge clk);
   endtask

   localparam logic [31:0] NOOP = 32'h4000_0000;

   initial begin
      logic [31:0] acc, w;
      int d0, e0, nb, sel;

      rstn = 1'b0;
      CS   = 1'b1;
      SCLK = 1'b0;
      MOSI = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst:miso", 32'(MISO), 32'd0);
      check("rst:done", 32'(frame_done), 32'd0);
      check("rst:err",  32'(frame_err), 32'd0);
      check("rst:last", last_cmd, 32'h0);
      rstn = 1'b1;
      repeat (6) @(negedge clk);
      check("rst:spurious", 32'(done_seen + err_seen), 32'd0);

      // Out-of-range CONVERT after reset: zero responses, counter untouched.
      for (int k = 0; k < 3; k++) begin
         do_frame("ch17", 32'h0011_0000, 32);
         check("ch17:zero", last_miso, 32'h0);
      end

      // CONVERT ch5 x4, then CLEAR and restart the count.
      do_frame("ch5a", 32'h0005_0000, 32);
      do_frame("ch5b", 32'h0005_0000, 32);
      do_frame("ch5c", 32'h0005_0000, 32);
      check("ch5:f3", last_miso, 32'h0000_5000);
      do_frame("ch5d", 32'h0005_0000, 32);
      check("ch5:f4", last_miso, 32'h0000_5001);
      do_frame("clear", 32'h6A00_0000, 32);
      do_frame("clr_c1", 32'h0005_0000, 32);
      do_frame("clr_c2", 32'h0005_0000, 32);
      do_frame("clr_n1", NOOP, 32);
      check("clr:c1", last_miso, 32'h0000_5000);
      do_frame("clr_n2", NOOP, 32);
      check("clr:c2", last_miso, 32'h0000_5001);

      // WRITE then READ of the same register, then two CONVERTs to drain.
      do_frame("wr3", 32'h8003_BEEF, 32);
      do_frame("rd3", 32'hC003_0000, 32);
      do_frame("cv0a", 32'h0000_0000, 32);
      check("wr3:resp", last_miso, 32'hFFFF_BEEF);
      do_frame("cv0b", 32'h0000_0000, 32);
      check("rd3:resp", last_miso, 32'h0000_BEEF);

      // Chip-id read and out-of-range read.
      do_frame("rd255", 32'hC0FF_0000, 32);
      do_frame("rd100", 32'hC064_0000, 32);
      do_frame("rdn1", NOOP, 32);
      check("rd255:resp", last_miso, 32'h0000_0020);
      do_frame("rdn2", NOOP, 32);
      check("rd100:resp", last_miso, 32'h0000_0000);

      // Short frame must neither write nor advance the pipeline.
      do_frame("wr7", 32'h8007_1234, 32);
      do_frame("short", 32'h8007_5555, 31);
      do_frame("rd7", 32'hC007_0000, 32);
      do_frame("s_n1", NOOP, 32);
      check("short:pipe", last_miso, 32'hFFFF_1234);
      do_frame("s_n2", NOOP, 32);
      check("short:reg", last_miso, 32'h0000_1234);

      // Reset pulse mid-frame with CS held low.
      do_frame("pre", 32'h8005_1234, 32);
      cs_assert();
      acc = 32'h0;
      shift_bits(32'h8005_4321, 0, 10, acc);
      d0 = done_seen;
      e0 = err_seen;
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      check("midrst:miso", 32'(MISO), 32'd0);
      check("midrst:done", 32'(frame_done), 32'd0);
      check("midrst:err",  32'(frame_err), 32'd0);
      check("midrst:last", last_cmd, 32'h0);
      rstn = 1'b1;
      model_reset();
      acc = 32'h0;
      shift_bits(32'h8005_4321, 10, 22, acc);
      check("midrst:ignored_miso", acc, 32'h0);
      cs_release();
      check("midrst:no_done", 32'(done_seen - d0), 32'd0);
      check("midrst:no_err",  32'(err_seen - e0),  32'd0);
      check("midrst:last2", last_cmd, 32'h0);
      do_frame("post_rd5", 32'hC005_0000, 32);
      do_frame("post_n1", NOOP, 32);
      do_frame("post_n2", NOOP, 32);
      check("post:reg5", last_miso, 32'h0000_0000);

      // Randomized frames against the model.
      for (int k = 0; k < 30; k++) begin
         w   = $urandom;
         sel = $urandom_range(0, 9);
         case (sel)
            0, 1, 2: begin
               w[31:30] = 2'b00;
               w[21:16] = 6'($urandom_range(0, 20));
            end
            3, 4: begin
               w[31:30] = 2'b10;
               w[23:16] = (sel == 4) ? 8'($urandom) : 8'($urandom_range(0, 15));
            end
            5, 6: begin
               w[31:30] = 2'b11;
               w[23:16] = (sel == 6) ? (($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom))
                                     : 8'($urandom_range(0, 15));
            end
            7: w = 32'h6A00_0000;
            8: w[31:30] = 2'b01;
            default: ;
         endcase
         nb = 32;
         if ($urandom_range(0, 9) == 0) nb = ($urandom_range(0, 1) == 1) ? 31 : 33;
         do_frame("rand", w, nb);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
